fsm_probe_sequencer: RTL

Stimulus sequencer and response checker for the FsmProbe block (inputs i, j; Mealy outputs x, y). It holds a programmed list of {i,j} vectors and replays them into the probe one per clock, starting from a freshly reset probe. It captures each {x,y} response and, when compiled in, compares it against an expected value. It sits between the bring-up control logic and the probe and owns the probe's reset during a run.

---
 rtl/probe_seq_pkg.sv | 23 ++
 rtl/probe_seq_buf.sv | 24 ++
 rtl/fsm_probe_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/probe_seq_pkg.sv
// Shared types for the FsmProbe stimulus sequencer.
// PROBE_SEQ_CHECK_EN widens each entry with the expected {x,y} response.
package probe_seq_pkg;

  typedef enum logic [1:0] {IDLE, PRST, RUN, DONE} state_t;

`ifdef PROBE_SEQ_CHECK_EN
  typedef struct packed {
    logic i;
    logic j;
    logic x_exp;
    logic y_exp;
  } entry_t;
`else
  typedef struct packed {
    logic i;
    logic j;
  } entry_t;
`endif

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/probe_seq_buf.sv
// Stimulus storage: DEPTH entries, one synchronous write port, combinational read.
module probe_seq_buf
  import probe_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fsm_probe_sequencer.sv
// Replays a programmed {i,j} list into a freshly reset FsmProbe and captures {x,y}.
// PROBE_SEQ_CHECK_EN adds per-entry expected responses and a mismatch counter.
//
// state | meaning
// IDLE  | accept loads/clear, wait for start
// PRST  | one-cycle probe reset, rewind read pointer
// RUN   | drive entry rd_ptr, capture probe response
// DONE  | one-cycle done pulse, back to IDLE
module fsm_probe_sequencer
  import probe_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [ENTRY_W-1:0] load_data,
  output logic               load_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   entries,
  output logic               probe_rstN,
  output logic               probe_i,
  output logic               probe_j,
  input  logic               probe_x,
  input  logic               probe_y,
  output logic               resp_valid,
  output logic [1:0]         resp_data,
  output logic [CNT_W-1:0]   err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state;
  logic [CNT_W-1:0] rd_ptr;
  logic [AW-1:0]    rd_addr;
  entry_t           rd_entry;
  logic             wr_en;
  logic             last;

  // start wins over load/clear so a run never sees its entry count change underneath it
  assign load_ready = (state == IDLE) && (entries < CNT_W'(DEPTH)) && !start;
  assign wr_en      = load_ready && load_valid && !clear;
  assign last       = (rd_ptr == entries - CNT_W'(1));
  // outputs are registered, so RUN fetches the entry for the following cycle
  assign rd_addr    = (state == RUN) ? rd_ptr[AW-1:0] + AW'(1) : rd_ptr[AW-1:0];

  probe_seq_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (entries[AW-1:0]),
    .wr_data (entry_t'(load_data)),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

`ifdef PROBE_SEQ_CHECK_EN
  logic [1:0] exp_xy;
`else
  assign err_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      entries    <= '0;
      rd_ptr     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      probe_rstN <= 1'b0;
      probe_i    <= 1'b0;
      probe_j    <= 1'b0;
`ifdef PROBE_SEQ_CHECK_EN
      exp_xy     <= '0;
      err_count  <= '0;
`endif
    end else begin
      done       <= 1'b0;
      resp_valid <= 1'b0;
      probe_rstN <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (entries != '0) begin
              state      <= PRST;
              probe_rstN <= 1'b0;
              rd_ptr     <= '0;
`ifdef PROBE_SEQ_CHECK_EN
              err_count  <= '0;
`endif
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (clear) begin
            entries <= '0;
          end else if (wr_en) begin
            entries <= entries + CNT_W'(1);
          end
        end
        PRST: begin
          state   <= RUN;
          probe_i <= rd_entry.i;
          probe_j <= rd_entry.j;
`ifdef PROBE_SEQ_CHECK_EN
          exp_xy  <= {rd_entry.x_exp, rd_entry.y_exp};
`endif
        end
        RUN: begin
          resp_valid <= 1'b1;
          resp_data  <= {probe_x, probe_y};
`ifdef PROBE_SEQ_CHECK_EN
          if ({probe_x, probe_y} != exp_xy) err_count <= err_count + CNT_W'(1);
`endif
          if (last) begin
            state   <= DONE;
            done    <= 1'b1;
            probe_i <= 1'b0;
            probe_j <= 1'b0;
          end else begin
            rd_ptr  <= rd_ptr + CNT_W'(1);
            probe_i <= rd_entry.i;
            probe_j <= rd_entry.j;
`ifdef PROBE_SEQ_CHECK_EN
            exp_xy  <= {rd_entry.x_exp, rd_entry.y_exp};
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
